// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared constants, state type and full-adder helper for popcount_seq
package popcount_pkg;
   localparam int DATA_W     = 32;
   localparam int CHUNK_W    = 8;
   localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
   localparam int RES_W      = $clog2(DATA_W + 1);
   localparam int CNT_W      = 4;
   localparam int IDX_W      = $clog2(NUM_CHUNKS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // {carry, sum} of a single full-adder cell
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction
endpackage

// File: rtl/popcount_seq_chunk_popcnt.sv
// rtl/popcount_seq_chunk_popcnt.sv - combinational 8-bit bit counter built from adder cells
module chunk_popcnt
   import popcount_pkg::*;
(
   input  logic [CHUNK_W-1:0] din,
   output logic [CNT_W-1:0]   cnt
);
   logic [1:0] fa0, fa1, fa2, fa3;
   logic       c3, c5;

   assign fa0 = full_add(din[0], din[1], din[2]);
   assign fa1 = full_add(din[3], din[4], din[5]);
   assign fa2 = full_add(fa0[0], fa1[0], din[6]);

   // weight-1 column closes with a half add of the last bit
   assign cnt[0] = fa2[0] ^ din[7];
   assign c3     = fa2[0] & din[7];

   assign fa3    = full_add(fa0[1], fa1[1], fa2[1]);
   assign cnt[1] = fa3[0] ^ c3;
   assign c5     = fa3[0] & c3;

   assign cnt[2] = fa3[1] ^ c5;
   assign cnt[3] = fa3[1] & c5;
endmodule

// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - multi-cycle popcount with start/busy/done handshake
// Optional early finish on an all-zero remainder: POPCOUNT_SEQ_EARLY_EXIT_EN
module popcount_seq
   import popcount_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] operand,
   output logic              busy,
   output logic              done,
   output logic [RES_W-1:0]  result
);
   state_t             state_q, state_d;
   logic [DATA_W-1:0]  shift_q, shift_d, shifted;
   logic [RES_W-1:0]   acc_q, acc_d, acc_sum;
   logic [RES_W-1:0]   result_q, result_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   chunk_cnt;
   logic               last_chunk;

   chunk_popcnt u_chunk (
      .din (shift_q[CHUNK_W-1:0]),
      .cnt (chunk_cnt)
   );

   assign shifted = shift_q >> CHUNK_W;
   assign acc_sum = acc_q + RES_W'(chunk_cnt);

`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
   assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1)) || (shifted == '0);
`else
   assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
`endif

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               shift_d = operand;
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d   = acc_sum;
            shift_d = shifted;
            idx_d   = idx_q + IDX_W'(1);
            busy_d  = 1'b1;
            if (last_chunk) begin
               result_d = acc_sum;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - scoreboard bench for popcount_seq
module tb_popcount_seq;
`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam logic [31:0] T4_OP  = EARLY ? 32'hF000000F : 32'h0000000F;
   localparam int          T4_EXP = EARLY ? 8 : 4;

   typedef struct {
      int res;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] operand = '0;
   logic        busy, done;
   logic [5:0]  result;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_start = 0;
   int   n_done = 0;

   popcount_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .operand (operand),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] op);
      logic [31:0] s;
      s = op;
      for (int i = 1; i <= 4; i++) begin
         s = s >> 8;
         if ((EARLY && s == 0) || i == 4) return i;
      end
      return 4;
   endfunction

   // Call at a negedge; returns at the negedge following the accepting edge.
   task automatic do_start(input logic [31:0] op, input int exp, input bit push);
      start   = 1'b1;
      operand = op;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      operand = $urandom;
      if (push) begin
         sb_q.push_back('{res: exp, cyc: cyc + exp_lat(op) - 1 + 1});
         n_start++;
      end
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         n_done++;
         if (sb_q.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("result", int'(result), e.res);
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] op;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      rst = 1'b0;
      @(negedge clk);

      // all ones: busy through four RUN cycles, then DONE, then IDLE
      do_start(32'hFFFFFFFF, 32, 1'b1);
      check("ffff_busy0", int'(busy), 1);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check("ffff_busy_run", int'(busy), 1);
      end
      @(negedge clk);
      check("ffff_busy_done", int'(busy), 0);
      check("ffff_done_seen", int'(done), 1);
      @(negedge clk);
      check("ffff_idle_busy", int'(busy), 0);
      check("ffff_result_hold", int'(result), 32);

      do_start(32'h80000001, 2, 1'b1);
      wait_done("t80000001");
      @(negedge clk);
      do_start(32'h00000000, 0, 1'b1);
      wait_done("tzero");
      @(negedge clk);

      // start while RUN is ignored
      do_start(T4_OP, T4_EXP, 1'b1);
      @(negedge clk);
      start   = 1'b1;
      operand = 32'hFFFFFFFF;
      @(negedge clk);
      start   = 1'b0;
      wait_done("tignore");
      repeat (3) @(negedge clk);
      check("ignore_result_hold", int'(result), T4_EXP);
      check("ignore_busy", int'(busy), 0);

      // back-to-back start in the DONE cycle
      do_start(32'hFFFFFFFF, 32, 1'b1);
      wait_done("tb2b_a");
      do_start(32'h12345678, 13, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("b2b_result_hold", int'(result), 32);
         @(negedge clk);
      end
      check("b2b_result_hold_last", int'(result), 32);
      @(negedge clk);
      check("b2b_done", int'(done), 1);
      @(negedge clk);

      // reset mid-RUN aborts without a done pulse
      do_start(32'hFFFFFFFF, 0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_result", int'(result), 0);
      repeat (5) @(negedge clk);
      check("abort_no_done", int'(done), 0);
      do_start(32'hAAAAAAAA, 16, 1'b1);
      wait_done("taaaa");

      // random operands with random spacing, including back-to-back
      for (int n = 0; n < 200; n++) begin
         op = $urandom;
         if (n % 7 == 0) op = op & 32'h000000FF;
         if (n % 11 == 0) op = 32'h0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_start(op, $countones(op), 1'b1);
         wait_done("trand");
      end

      repeat (4) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      check("done_vs_start", n_done, n_start);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
